master_axi_4_burst: RTL and testbench

Parametrised AXI4 (full) burst master, successor to the single-beat AXI4-lite master in the core's memory path. Independent read and write engines issue INCR bursts of 1–256 beats and may run concurrently. Each engine has its own request/stream interface. Non-OKAY responses are reported per transaction, and an optional 4 KB-boundary guard can be compiled in.

---
 rtl/master_axi_4_burst_if.sv | 54 +++++
 rtl/master_axi_4_burst.sv | 193 +++++++++++++++++++
 tb/tb_master_axi_4_burst.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/master_axi_4_burst_if.sv
// AXI4 (full) bus between the burst master and a slave.
interface master_axi_4_burst_if #(
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4
);
  logic [AXI_ID_WIDTH-1:0]     AWID;
  logic [AXI_ADDR_WIDTH-1:0]   AWADDR;
  logic [7:0]                  AWLEN;
  logic [2:0]                  AWSIZE;
  logic [1:0]                  AWBURST;
  logic [2:0]                  AWPROT;
  logic                        AWVALID;
  logic                        AWREADY;
  logic [AXI_DATA_WIDTH-1:0]   WDATA;
  logic [AXI_DATA_WIDTH/8-1:0] WSTRB;
  logic                        WLAST;
  logic                        WVALID;
  logic                        WREADY;
  logic [AXI_ID_WIDTH-1:0]     BID;
  logic [1:0]                  BRESP;
  logic                        BVALID;
  logic                        BREADY;
  logic [AXI_ID_WIDTH-1:0]     ARID;
  logic [AXI_ADDR_WIDTH-1:0]   ARADDR;
  logic [7:0]                  ARLEN;
  logic [2:0]                  ARSIZE;
  logic [1:0]                  ARBURST;
  logic [2:0]                  ARPROT;
  logic                        ARVALID;
  logic                        ARREADY;
  logic [AXI_ID_WIDTH-1:0]     RID;
  logic [AXI_DATA_WIDTH-1:0]   RDATA;
  logic [1:0]                  RRESP;
  logic                        RLAST;
  logic                        RVALID;
  logic                        RREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWPROT, AWVALID, input AWREADY,
    output WDATA, WSTRB, WLAST, WVALID, input WREADY,
    input BID, BRESP, BVALID, output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARPROT, ARVALID, input ARREADY,
    input RID, RDATA, RRESP, RLAST, RVALID, output RREADY
  );

  modport slave (
    input AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWPROT, AWVALID, output AWREADY,
    input WDATA, WSTRB, WLAST, WVALID, output WREADY,
    output BID, BRESP, BVALID, input BREADY,
    input ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARPROT, ARVALID, output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID, input RREADY
  );
endinterface

// File: rtl/master_axi_4_burst.sv
// AXI4 INCR burst master with independent read and write engines.
// Optional 4 KB-crossing reject path: define MASTER_AXI_4_BURST_4K_CHECK_EN.
module master_axi_4_burst #(
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_ID         = 0
) (
  input  logic                        AXI_ACLK,
  input  logic                        AXI_ARESET,
  input  logic                        wr_req_valid,
  output logic                        wr_req_ready,
  input  logic [AXI_ADDR_WIDTH-1:0]   wr_addr,
  input  logic [7:0]                  wr_len,
  input  logic                        wr_data_valid,
  output logic                        wr_data_ready,
  input  logic [AXI_DATA_WIDTH-1:0]   wr_data,
  input  logic [AXI_DATA_WIDTH/8-1:0] wr_strb,
  output logic                        wr_done,
  output logic [1:0]                  wr_resp,
  input  logic                        rd_req_valid,
  output logic                        rd_req_ready,
  input  logic [AXI_ADDR_WIDTH-1:0]   rd_addr,
  input  logic [7:0]                  rd_len,
  output logic                        rd_data_valid,
  input  logic                        rd_data_ready,
  output logic [AXI_DATA_WIDTH-1:0]   rd_data,
  output logic [1:0]                  rd_resp,
  output logic                        rd_last,
  master_axi_4_burst_if.master        m_axi
);
  localparam int         STRB_W = AXI_DATA_WIDTH / 8;
  localparam logic [2:0] SIZE   = 3'($clog2(STRB_W));
  localparam logic [AXI_ID_WIDTH-1:0] ID = AXI_ID[AXI_ID_WIDTH-1:0];

  localparam logic [2:0] W_IDLE = 3'd0;
  localparam logic [2:0] W_ADDR = 3'd1;
  localparam logic [2:0] W_DATA = 3'd2;
  localparam logic [2:0] W_RESP = 3'd3;
  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_ADDR = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;
`ifdef MASTER_AXI_4_BURST_4K_CHECK_EN
  localparam logic [2:0] W_REJ  = 3'd4;
  localparam logic [1:0] R_REJ  = 2'd3;
`endif

  logic [2:0]                w_state;
  logic [AXI_ADDR_WIDTH-1:0] w_addr_q;
  logic [7:0]                w_len_q;
  logic [7:0]                w_cnt;
  logic                      w_done_q;
  logic [1:0]                w_resp_q;
  logic [1:0]                r_state;
  logic [AXI_ADDR_WIDTH-1:0] r_addr_q;
  logic [7:0]                r_len_q;
  logic                      w_beat;
  logic                      unused_ids;

`ifdef MASTER_AXI_4_BURST_4K_CHECK_EN
  // Burst end offset within the 4 KB page; anything past 4096 spills into the next page.
  function automatic logic crosses_4k(input logic [11:0] off, input logic [7:0] len);
    logic [20:0] span;
    span = 21'(off) + ((21'(len) + 21'd1) << $clog2(STRB_W));
    return span > 21'd4096;
  endfunction

  logic w_rej, r_rej;
  assign w_rej = crosses_4k(wr_addr[11:0], wr_len);
  assign r_rej = crosses_4k(rd_addr[11:0], rd_len);
`endif

  assign w_beat = m_axi.WVALID && m_axi.WREADY;

  always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
    if (AXI_ARESET) begin
      w_state  <= W_IDLE;
      w_addr_q <= '0;
      w_len_q  <= '0;
      w_cnt    <= '0;
      w_done_q <= 1'b0;
      w_resp_q <= 2'b00;
    end else begin
      w_done_q <= 1'b0;
      case (w_state)
        W_IDLE: if (wr_req_valid) begin
          w_addr_q <= wr_addr;
          w_len_q  <= wr_len;
          w_cnt    <= '0;
`ifdef MASTER_AXI_4_BURST_4K_CHECK_EN
          w_state  <= w_rej ? W_REJ : W_ADDR;
`else
          w_state  <= W_ADDR;
`endif
        end
        W_ADDR: if (m_axi.AWREADY) w_state <= W_DATA;
        W_DATA: if (w_beat) begin
          if (m_axi.WLAST) w_state <= W_RESP;
          else             w_cnt   <= w_cnt + 8'd1;
        end
        W_RESP: if (m_axi.BVALID) begin
          w_done_q <= 1'b1;
          w_resp_q <= m_axi.BRESP;
          w_state  <= W_IDLE;
        end
`ifdef MASTER_AXI_4_BURST_4K_CHECK_EN
        // Swallow the caller's beats so its stream stays aligned, then report SLVERR.
        W_REJ: if (wr_data_valid) begin
          if (w_cnt == w_len_q) begin
            w_done_q <= 1'b1;
            w_resp_q <= 2'b10;
            w_state  <= W_IDLE;
          end else begin
            w_cnt <= w_cnt + 8'd1;
          end
        end
`endif
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
    if (AXI_ARESET) begin
      r_state  <= R_IDLE;
      r_addr_q <= '0;
      r_len_q  <= '0;
    end else begin
      case (r_state)
        R_IDLE: if (rd_req_valid) begin
          r_addr_q <= rd_addr;
          r_len_q  <= rd_len;
`ifdef MASTER_AXI_4_BURST_4K_CHECK_EN
          r_state  <= r_rej ? R_REJ : R_ADDR;
`else
          r_state  <= R_ADDR;
`endif
        end
        R_ADDR: if (m_axi.ARREADY) r_state <= R_DATA;
        R_DATA: if (m_axi.RVALID && rd_data_ready && m_axi.RLAST) r_state <= R_IDLE;
`ifdef MASTER_AXI_4_BURST_4K_CHECK_EN
        R_REJ:  if (rd_data_ready) r_state <= R_IDLE;
`endif
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Ready is masked by reset so callers never see a grant while the engines are held.
  assign wr_req_ready = (w_state == W_IDLE) && !AXI_ARESET;
  assign rd_req_ready = (r_state == R_IDLE) && !AXI_ARESET;
  assign wr_done      = w_done_q;
  assign wr_resp      = w_resp_q;

  assign m_axi.AWID    = ID;
  assign m_axi.AWADDR  = w_addr_q;
  assign m_axi.AWLEN   = w_len_q;
  assign m_axi.AWSIZE  = SIZE;
  assign m_axi.AWBURST = 2'b01;
  assign m_axi.AWPROT  = 3'b000;
  assign m_axi.AWVALID = (w_state == W_ADDR);
  assign m_axi.WDATA   = wr_data;
  assign m_axi.WSTRB   = wr_strb;
  assign m_axi.WVALID  = (w_state == W_DATA) && wr_data_valid;
  assign m_axi.WLAST   = (w_state == W_DATA) && (w_cnt == w_len_q);
  assign m_axi.BREADY  = (w_state == W_RESP);

  assign m_axi.ARID    = ID;
  assign m_axi.ARADDR  = r_addr_q;
  assign m_axi.ARLEN   = r_len_q;
  assign m_axi.ARSIZE  = SIZE;
  assign m_axi.ARBURST = 2'b01;
  assign m_axi.ARPROT  = 3'b000;
  assign m_axi.ARVALID = (r_state == R_ADDR);
  assign m_axi.RREADY  = (r_state == R_DATA) && rd_data_ready;

`ifdef MASTER_AXI_4_BURST_4K_CHECK_EN
  assign wr_data_ready = (w_state == W_DATA) ? m_axi.WREADY : (w_state == W_REJ);
  assign rd_data_valid = ((r_state == R_DATA) && m_axi.RVALID) || (r_state == R_REJ);
  assign rd_data       = (r_state == R_REJ) ? '0    : m_axi.RDATA;
  assign rd_resp       = (r_state == R_REJ) ? 2'b10 : m_axi.RRESP;
  assign rd_last       = (r_state == R_REJ) ? 1'b1  : m_axi.RLAST;
`else
  assign wr_data_ready = (w_state == W_DATA) && m_axi.WREADY;
  assign rd_data_valid = (r_state == R_DATA) && m_axi.RVALID;
  assign rd_data       = m_axi.RDATA;
  assign rd_resp       = m_axi.RRESP;
  assign rd_last       = m_axi.RLAST;
`endif

  // Single outstanding transaction per direction, so response IDs carry no information.
  assign unused_ids = ^{m_axi.BID, m_axi.RID};
endmodule

// File: tb/tb_master_axi_4_burst.sv
// Bench for master_axi_4_burst: randomized AXI slave plus a word-level memory reference.
`timescale 1ns/1ps
module tb_master_axi_4_burst;
  localparam int N = 64, AW = 32, IW = 4, SW = N / 8;
`ifdef MASTER_AXI_4_BURST_4K_CHECK_EN
  localparam bit CHK4K = 1'b1;
`else
  localparam bit CHK4K = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          wr_req_valid, wr_req_ready, wr_data_valid, wr_data_ready, wr_done;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [7:0]    wr_len, rd_len;
  logic [N-1:0]  wr_data, rd_data;
  logic [SW-1:0] wr_strb;
  logic [1:0]    wr_resp, rd_resp;
  logic          rd_req_valid, rd_req_ready, rd_data_valid, rd_data_ready, rd_last;

  master_axi_4_burst_if #(.AXI_DATA_WIDTH(N), .AXI_ADDR_WIDTH(AW), .AXI_ID_WIDTH(IW)) bus();

  master_axi_4_burst #(.AXI_DATA_WIDTH(N), .AXI_ADDR_WIDTH(AW), .AXI_ID_WIDTH(IW), .AXI_ID(0)) dut (
    .AXI_ACLK(clk), .AXI_ARESET(rst),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready), .wr_addr(wr_addr), .wr_len(wr_len),
    .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready), .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_done(wr_done), .wr_resp(wr_resp),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_addr(rd_addr), .rd_len(rd_len),
    .rd_data_valid(rd_data_valid), .rd_data_ready(rd_data_ready), .rd_data(rd_data),
    .rd_resp(rd_resp), .rd_last(rd_last),
    .m_axi(bus)
  );

  int checks = 0, errors = 0;
  int cyc = 0, b_cyc = -10, aw_hs = 0, ar_hs = 0, aw_dly = 0, ar_dly = 1;
  logic [1:0]  bresp_cfg = 2'b00;
  logic [63:0] ref_mem [int];
  logic [63:0] slv_mem [int];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] dflt(input int k);
    return {32'(k) ^ 32'h5A5A_0000, ~32'(k)};
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d, input logic [7:0] s);
    for (int b = 0; b < 8; b++) if (s[b]) old[8*b +: 8] = d[8*b +: 8];
    return old;
  endfunction

  function automatic bit rejected(input logic [31:0] a, input logic [7:0] l);
    return CHK4K && ((int'(a[11:0]) + (int'(l) + 1) * SW) > 4096);
  endfunction

  function automatic logic [63:0] ref_word(input int k);
    return ref_mem.exists(k) ? ref_mem[k] : dflt(k);
  endfunction

  // ---------------- AXI slave model ----------------
  int wbeat = 0, rbeat = 0, awwait = 0, arwait = 0, bpend = 0, sk = 0;
  bit rhs;
  logic [31:0] awq_a[$], arq_a[$];
  logic [7:0]  awq_l[$], arq_l[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.AWREADY <= 0; bus.WREADY <= 0; bus.BVALID <= 0; bus.BRESP <= 0; bus.BID <= 0;
      bus.ARREADY <= 0; bus.RVALID <= 0; bus.RDATA <= 0; bus.RRESP <= 0; bus.RLAST <= 0; bus.RID <= 0;
      wbeat = 0; rbeat = 0; awwait = 0; arwait = 0; bpend = 0;
      awq_a.delete(); awq_l.delete(); arq_a.delete(); arq_l.delete();
    end else begin
      if (bus.AWVALID && bus.AWREADY) begin
        awq_a.push_back(bus.AWADDR); awq_l.push_back(bus.AWLEN); aw_hs++; awwait = 0; bus.AWREADY <= 0;
      end else if (bus.AWVALID) begin
        awwait++; bus.AWREADY <= (awwait >= aw_dly);
      end
      bus.WREADY <= 1'($urandom_range(1));
      if (bus.WVALID && bus.WREADY) begin
        chk("w_after_aw", 64'(awq_a.size() > 0), 64'd1);
        if (awq_a.size() > 0) begin
          sk = int'(awq_a[0] >> 3) + wbeat;
          slv_mem[sk] = merge(slv_mem.exists(sk) ? slv_mem[sk] : dflt(sk), bus.WDATA, bus.WSTRB);
          chk("wlast_pos", 64'(bus.WLAST), 64'(wbeat == int'(awq_l[0])));
          if (bus.WLAST) begin
            wbeat = 0; void'(awq_a.pop_front()); void'(awq_l.pop_front()); bpend++;
          end else wbeat++;
        end
      end
      if (bus.BVALID && bus.BREADY) begin
        bus.BVALID <= 0; b_cyc = cyc;
      end else if (!bus.BVALID && bpend > 0 && $urandom_range(1) == 1) begin
        bus.BVALID <= 1; bus.BRESP <= bresp_cfg; bpend--;
      end
      if (bus.ARVALID && bus.ARREADY) begin
        arq_a.push_back(bus.ARADDR); arq_l.push_back(bus.ARLEN); ar_hs++; arwait = 0; bus.ARREADY <= 0;
      end else if (bus.ARVALID) begin
        arwait++; bus.ARREADY <= (arwait >= ar_dly);
      end
      rhs = bus.RVALID && bus.RREADY;
      if (rhs) begin
        if (bus.RLAST) begin
          rbeat = 0; void'(arq_a.pop_front()); void'(arq_l.pop_front());
        end else rbeat++;
      end
      if (!bus.RVALID || rhs) begin
        if (arq_a.size() > 0 && $urandom_range(3) != 0) begin
          sk = int'(arq_a[0] >> 3) + rbeat;
          bus.RVALID <= 1; bus.RRESP <= 2'b00; bus.RLAST <= (rbeat == int'(arq_l[0]));
          bus.RDATA  <= slv_mem.exists(sk) ? slv_mem[sk] : dflt(sk);
        end else bus.RVALID <= 0;
      end
    end
  end

  // ---------------- caller-side tasks ----------------
  task automatic do_write(input logic [31:0] a, input logic [7:0] l, input int rst_at);
    logic [63:0] d[$];
    logic [7:0]  s[$];
    int i, t, aw0, k;
    bit rej;
    rej = rejected(a, l);
    for (int j = 0; j <= int'(l); j++) begin
      d.push_back({$urandom, $urandom}); s.push_back(8'($urandom));
    end
    aw0 = aw_hs;
    @(negedge clk);
    wr_req_valid = 1; wr_addr = a; wr_len = l;
    t = 0;
    while (!wr_req_ready && t < 100) begin @(negedge clk); t++; end
    chk("wr_req_wait", 64'(t < 100), 64'd1);
    @(negedge clk);
    wr_req_valid = 0; wr_addr = $urandom; wr_len = 8'($urandom);
    chk("awvalid_t1", 64'(bus.AWVALID), 64'(!rej));
    if (!rej) begin
      chk("awaddr", 64'(bus.AWADDR), 64'(a));
      chk("awlen", 64'(bus.AWLEN), 64'(l));
      chk("aw_consts", {bus.AWID, bus.AWSIZE, bus.AWBURST, bus.AWPROT}, {4'd0, 3'd3, 2'b01, 3'd0});
    end
    i = 0; t = 0;
    while (i <= int'(l) && t < 5000) begin
      if (i == rst_at) begin
        rst = 1; wr_data_valid = 0;
        #1;
        chk("rst_mid_valids", {bus.AWVALID, bus.WVALID, bus.WLAST, bus.BREADY, bus.ARVALID, bus.RREADY},
            6'b0);
        chk("rst_mid_done", {wr_done, wr_resp, wr_req_ready, rd_req_ready, rd_data_valid}, 6'b0);
        return;
      end
      wr_data_valid = ($urandom_range(3) != 0); wr_data = d[i]; wr_strb = s[i];
      #1;
      if (wr_data_valid && wr_data_ready) begin
        if (!rej) begin
          chk("wlast_beat", 64'(bus.WLAST), 64'(i == int'(l)));
          chk("wdata_pass", bus.WDATA, d[i]);
        end
        i++;
      end
      @(negedge clk); t++;
    end
    wr_data_valid = 0;
    chk("wr_beats_done", 64'(i), 64'(int'(l) + 1));
    t = 0;
    while (!wr_done && t < 200) begin @(negedge clk); t++; end
    chk("wr_done_seen", 64'(wr_done), 64'd1);
    chk("wr_resp", 64'(wr_resp), 64'(rej ? 2'b10 : bresp_cfg));
    if (!rej) chk("wr_done_latency", 64'(cyc), 64'(b_cyc + 1));
    @(negedge clk);
    chk("wr_done_pulse", 64'(wr_done), 64'd0);
    chk("aw_count", 64'(aw_hs - aw0), 64'(rej ? 0 : 1));
    if (!rej)
      for (int j = 0; j <= int'(l); j++) begin
        k = int'(a >> 3) + j;
        ref_mem[k] = merge(ref_word(k), d[j], s[j]);
      end
  endtask

  task automatic do_read(input logic [31:0] a, input logic [7:0] l, input int stall_at);
    int i, t, n, ar0, stall_left;
    bit rej;
    rej = rejected(a, l);
    n = rej ? 1 : int'(l) + 1;
    ar0 = ar_hs; stall_left = 3;
    @(negedge clk);
    rd_req_valid = 1; rd_addr = a; rd_len = l;
    t = 0;
    while (!rd_req_ready && t < 100) begin @(negedge clk); t++; end
    chk("rd_req_wait", 64'(t < 100), 64'd1);
    @(negedge clk);
    rd_req_valid = 0; rd_addr = $urandom; rd_len = 8'($urandom);
    chk("arvalid_t1", 64'(bus.ARVALID), 64'(!rej));
    if (!rej) begin
      chk("araddr", 64'(bus.ARADDR), 64'(a));
      chk("arlen", 64'(bus.ARLEN), 64'(l));
    end
    i = 0; t = 0;
    while (i < n && t < 5000) begin
      if (i == stall_at && stall_left > 0) begin
        rd_data_ready = 0; stall_left--;
      end else rd_data_ready = ($urandom_range(3) != 0);
      #1;
      if (!rd_data_ready) chk("rready_stall", 64'(bus.RREADY), 64'd0);
      if (rd_data_valid && rd_data_ready) begin
        chk("rd_data", rd_data, rej ? 64'd0 : ref_word(int'(a >> 3) + i));
        chk("rd_last", 64'(rd_last), 64'(i == n - 1));
        chk("rd_resp", 64'(rd_resp), 64'(rej ? 2'b10 : 2'b00));
        i++;
      end
      @(negedge clk); t++;
    end
    rd_data_ready = 0;
    chk("rd_beats_done", 64'(i), 64'(n));
    chk("ar_count", 64'(ar_hs - ar0), 64'(rej ? 0 : 1));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    wr_req_valid = 0; wr_addr = 0; wr_len = 0; wr_data_valid = 0; wr_data = 0; wr_strb = 0;
    rd_req_valid = 0; rd_addr = 0; rd_len = 0; rd_data_ready = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {wr_req_ready, rd_req_ready}, 2'b00);
    chk("rst_valids", {bus.AWVALID, bus.WVALID, bus.WLAST, bus.BREADY, bus.ARVALID, bus.RREADY}, 6'b0);
    chk("rst_outs", {wr_done, wr_resp, rd_data_valid}, 4'b0);
    rst = 0;
    @(negedge clk);
    chk("rel_ready", {wr_req_ready, rd_req_ready}, 2'b11);

    aw_dly = 2;
    do_write(32'h8000_0000, 8'd3, -1);
    aw_dly = 0;
    do_read(32'h0000_0100, 8'd7, 4);

    fork
      do_write(32'h2000_0000, 8'd5, -1);
      do_read(32'h3000_0000, 8'd5, -1);
    join

    bresp_cfg = 2'b11;
    do_write(32'h4000_0000, 8'd2, -1);
    bresp_cfg = 2'b00;
    do_write(32'h4000_0100, 8'd0, -1);
    do_read(32'h4000_0100, 8'd0, -1);

    do_write(32'h5000_0000, 8'd7, 2);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("post_rst_ready", {wr_req_ready, rd_req_ready}, 2'b11);

    do_write(32'h0000_0FF8, 8'd1, -1);
    do_read(32'h0000_0FF8, 8'd1, -1);

    do_write(32'h6000_0000, 8'd255, -1);
    do_read(32'h6000_0000, 8'd255, -1);

    for (int it = 0; it < 10; it++) begin
      logic [31:0] a;
      logic [7:0]  l;
      a = 32'h1000_0000 + 32'(8 * $urandom_range(0, 1023));
      l = 8'($urandom_range(0, 15));
      ar_dly = $urandom_range(0, 3);
      aw_dly = $urandom_range(0, 3);
      do_write(a, l, -1);
      do_read(a, l, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
